// File: rtl/alu_result_buffer_pkg.sv
// Shared definitions for the ALU result buffer and neighbouring ALU stages.
package alu_result_buffer_pkg;

    // Default datapath width of a result word.
    localparam int WIDTH_DEFAULT = 32;

    // Width of the occupancy counter (holds 0..2).
    localparam int LEVEL_W = 2;

    // Flag bundle stored alongside each result word.
    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_result_buffer_flag_gen.sv
// Combinational zero / negative detection on a result word.
module alu_flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    output logic             zero,
    output logic             neg
);

    assign zero = (data == '0);
    assign neg  = data[WIDTH-1];

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry skid/result buffer between the ALU result mux and its consumer.
// Flags are computed at push time and stored with each word; outputs are
// driven from registered state only and read zero when the buffer is empty.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_carry,
    input  logic               in_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_neg,
    output logic               out_carry,
    output logic               out_ovf,
    output logic [LEVEL_W-1:0] level,
    output logic [7:0]         xfer_count
);

    logic [LEVEL_W-1:0] level_reg;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic               alive_reg;
    logic [7:0]         xfer_reg;

    logic [WIDTH-1:0]   entry_data [2];
    flags_t             entry_flags [2];

    logic               in_zero;
    logic               in_neg;
    flags_t             push_flags;
    flags_t             head_flags;
    logic               push;
    logic               pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .data (in_data),
        .zero (in_zero),
        .neg  (in_neg)
    );

    assign push_flags = '{zero: in_zero, neg: in_neg, carry: in_carry, ovf: in_ovf};

    // alive_reg keeps in_ready low during reset and until the first edge after release.
    assign in_ready  = alive_reg && (level_reg != LEVEL_W'(DEPTH));
    assign out_valid = (level_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage entries: one register pair per slot, written when the write pointer selects it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;
        flags_t           flags_reg;

        // Capture word and its flags on a push addressed to this slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg  <= '0;
                flags_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg  <= in_data;
                flags_reg <= push_flags;
            end
        end

        assign entry_data[gi]  = data_reg;
        assign entry_flags[gi] = flags_reg;
    end

    // Pointers, occupancy, transfer counter and post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg  <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            alive_reg  <= 1'b0;
            xfer_reg   <= '0;
        end else begin
            alive_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                xfer_reg   <= xfer_reg + 8'd1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LEVEL_W'(1);
                2'b01:   level_reg <= level_reg - LEVEL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Head entry is masked to zero while the buffer is empty.
    always_comb begin
        out_data   = '0;
        head_flags = '0;
        if (out_valid) begin
            out_data   = entry_data[rd_ptr_reg];
            head_flags = entry_flags[rd_ptr_reg];
        end
    end

    assign out_zero   = head_flags.zero;
    assign out_neg    = head_flags.neg;
    assign out_carry  = head_flags.carry;
    assign out_ovf    = head_flags.ovf;
    assign level      = level_reg;
    assign xfer_count = xfer_reg;

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of the result word.
REQ-002 Parameter: DEPTH, 2, number of buffer entries (fixed at 2; other values unsupported).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream result-select mux output is valid this cycle.
REQ-006 Port: in_ready  output  1  buffer can accept a result this cycle.
REQ-007 Port: in_data  input  WIDTH  selected result word from the 32-bit 2:1 result mux.
REQ-008 Port: in_carry  input  1  carry-out of the selected operation.
REQ-009 Port: in_ovf  input  1  signed overflow of the selected operation.
REQ-010 Port: out_valid  output  1  head entry is valid.
REQ-011 Port: out_ready  input  1  downstream consumer accepts the head entry.
REQ-012 Port: out_data  output  WIDTH  head result word.
REQ-013 Port: out_zero  output  1  head result equals zero.
REQ-014 Port: out_neg  output  1  head result bit WIDTH-1.
REQ-015 Port: out_carry  output  1  stored carry of head entry.
REQ-016 Port: out_ovf  output  1  stored overflow of head entry.
REQ-017 Port: level  output  2  current occupancy, 0..2.
REQ-018 Port: xfer_count  output  8  number of completed output transfers, wraps 255->0.

Function
REQ-019 Push occurs when in_valid and in_ready are both 1 at a rising edge; pop occurs when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL be 1 exactly when level < 2, derived from registered state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 exactly when level > 0, registered.
REQ-022 Entries SHALL leave in push order (FIFO); pointers wrap 1->0.
REQ-023 out_zero and out_neg SHALL be computed from in_data at push time and stored with the entry.
REQ-024 Latency: a result pushed into an empty buffer at edge N SHALL appear on out_* after edge N (usable in cycle N+1); no same-cycle pass-through.
REQ-025 Level update: push only +1; pop only -1; push and pop together leave level unchanged.
REQ-026 At level 2 in_ready is 0; in_valid is ignored and input data is not stored.
REQ-027 At level 0 out_ready is ignored; level and xfer_count unchanged.
REQ-028 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-029 xfer_count SHALL increment by 1 on every pop, modulo 256.
REQ-030 When out_valid=0, out_data and all flags SHALL read 0.
REQ-031 in_valid deasserting without a handshake SHALL have no effect; upstream may change in_data freely while in_ready=0.

Reset
REQ-032 While rst_n=0: level=0, in_ready=0, out_valid=0, out_data=0, out_zero/out_neg/out_carry/out_ovf=0, xfer_count=0, pointers=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-034 in_ready SHALL rise on the first rising edge after rst_n deasserts.

Structure
REQ-035 Shared package holds WIDTH default, the flag-bundle layout {zero, neg, carry, ovf}, and the level width constant.
REQ-036 One sub-module is natural: alu_flag_gen (combinational zero/negative from a WIDTH word), reused by other ALU stages.
REQ-037 Storage is two registered entries plus read/write pointers and a level counter; no inferred RAM.

Verification
REQ-038 Reset then single push in_data=0x00000000, carry=1 -> next cycle out_valid=1, out_data=0, out_zero=1, out_neg=0, out_carry=1; pop -> level=0, xfer_count=1.
REQ-039 Push 0x80000001 then 0x00000005 with out_ready=0 -> level=2, in_ready=0; third push 0xDEADBEEF ignored; drain yields 0x80000001 (out_neg=1) then 0x00000005.
REQ-040 Level=1, simultaneous push 0x11111111 and pop -> level stays 1, head becomes 0x11111111 next cycle.
REQ-041 Stall: out_ready=0 for 10 cycles with head 0x12345678 -> out_data and flags constant throughout.
REQ-042 256 continuous push/pop transfers at full throughput -> xfer_count wraps to 0, no bubbles after first fill.
REQ-043 Assert rst_n=0 asynchronously mid-cycle at level=2 -> out_valid=0, level=0 immediately, no entry emitted after release.
